gb_serial: RTL

Game Boy link-port controller. It implements the SB (FF01) and SC (FF02) registers and a bidirectional 8-bit serial shift engine that runs as clock master (internal 8192 Hz clock) or clock slave (external clock). It sits beside `timer` in `gb`. Its one-cycle `irq` sets IF bit 3 (serial, vector 0x58), so the link cable becomes the peer end of another Game Boy's transfer.

---
 rtl/gb_serial_defs.sv | 16 +
 rtl/gb_serial_sync.sv | 28 ++
 rtl/gb_serial.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gb_serial_defs.sv
// Shared constants for the Game Boy link-port controller: register offsets,
// SC bit positions, default divider and the shift-engine state type.
package gb_serial_defs;
    localparam logic [1:0] ADDR_SB     = 2'b01;
    localparam logic [1:0] ADDR_SC     = 2'b10;
    localparam int         CLK_DIV_DEF = 512;
    localparam int         SC_START    = 7;
    localparam int         SC_INT_CLK  = 0;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

    // Unimplemented SC bits (including CGB fast-speed) read back as 1.
    function automatic logic [7:0] sc_read(input logic start, input logic int_clk);
        return {start, 6'b111111, int_clk};
    endfunction
endpackage

// File: rtl/gb_serial_sync.sv
// Two-flop synchronizer for link-port pins, with a third flop to derive
// single-cycle rise/fall pulses. Idles high like the open-drain cable.
module gb_serial_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign q_o    = s2_q;
    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;
endmodule

// File: rtl/gb_serial.sv
// Game Boy link port: SB/SC registers and an 8-bit MSB-first shift engine,
// clocked either by an internal divider (master) or the cable clock (slave).
module gb_serial
    import gb_serial_defs::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_sel,
    input  logic [1:0] cpu_addr,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_di,
    output logic [7:0] cpu_do,
    output logic       irq,
    input  logic       ser_clk_in,
    input  logic       ser_data_in,
    output logic       ser_clk_out,
    output logic       ser_clk_oe,
    output logic       ser_data_out
);
    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

    state_e        state_q;
    logic [7:0]    sb_q;
    logic          start_q, int_clk_q;
    logic [2:0]    bitcnt_q;
    logic [DW-1:0] div_q;
    logic          sclk_q, so_q, irq_q;

    logic sck_rise, sck_fall, sck_lvl_unused;
    logic sdi, sdi_rise_unused, sdi_fall_unused;

    gb_serial_sync u_sck (
        .clk(clk), .reset(reset), .d_i(ser_clk_in),
        .q_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    gb_serial_sync u_sdi (
        .clk(clk), .reset(reset), .d_i(ser_data_in),
        .q_o(sdi), .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused)
    );

    logic div_wrap, rise_e, fall_e, wr_sb, wr_sc;

    assign div_wrap = (div_q == DW'(HALF - 1));
    assign wr_sb    = cpu_sel & cpu_wr & (cpu_addr == ADDR_SB);
    assign wr_sc    = cpu_sel & cpu_wr & (cpu_addr == ADDR_SC);

    // Edge source follows the current int_clk, so a mid-transfer switch
    // simply changes where the next edge comes from.
    always_comb begin
        rise_e = 1'b0;
        fall_e = 1'b0;
        if (state_q == ST_SHIFT) begin
            if (int_clk_q) begin
                rise_e = div_wrap & ~sclk_q;
                fall_e = div_wrap & sclk_q;
            end else begin
                rise_e = sck_rise;
                fall_e = sck_fall;
            end
        end
    end

    // CPU writes are applied after the shift-engine updates so they win.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sb_q      <= 8'h00;
            start_q   <= 1'b0;
            int_clk_q <= 1'b0;
            bitcnt_q  <= 3'd0;
            div_q     <= '0;
            sclk_q    <= 1'b1;
            so_q      <= 1'b1;
            irq_q     <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (state_q == ST_SHIFT && int_clk_q) begin
                div_q <= div_wrap ? '0 : div_q + 1'b1;
                if (div_wrap)
                    sclk_q <= ~sclk_q;
            end
            if (fall_e)
                so_q <= sb_q[7];
            if (rise_e) begin
                sb_q     <= {sb_q[6:0], sdi};
                bitcnt_q <= bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    start_q <= 1'b0;
                    state_q <= ST_IDLE;
                    irq_q   <= 1'b1;
                end
            end
            if (wr_sb)
                sb_q <= cpu_di;
            if (wr_sc) begin
                start_q   <= cpu_di[SC_START];
                int_clk_q <= cpu_di[SC_INT_CLK];
                if (cpu_di[SC_START]) begin
                    state_q  <= ST_SHIFT;
                    bitcnt_q <= 3'd0;
                    so_q     <= sb_q[7];
                    div_q    <= '0;
                    sclk_q   <= ~cpu_di[SC_INT_CLK];
                end else begin
                    state_q <= ST_IDLE;
                    sclk_q  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (cpu_addr)
            ADDR_SB: cpu_do = sb_q;
            ADDR_SC: cpu_do = sc_read(start_q, int_clk_q);
            default: cpu_do = 8'hFF;
        endcase
    end

    assign irq          = irq_q;
    assign ser_clk_out  = sclk_q;
    assign ser_clk_oe   = int_clk_q;
    assign ser_data_out = so_q;
endmodule
